// File: rtl/boot_image_loader.sv
// Consumer side of the bootloader byte queue: parses a framed boot image
// (16-bit word count, little-endian data words, XOR checksum) into instruction memory.
module boot_image_loader #(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              q_empty,
  input  logic [7:0]        q_data,
  input  logic              wr_active,
  output logic              q_remove,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  state_t            state, state_nxt;
  logic [15:0]       len, rx_words;
  logic [1:0]        idx;
  logic [2:0][7:0]   lane;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       len_full;
  logic              consuming, restart, lane3_pop, last_word;

  assign len_full  = {q_data, len[7:0]};
  assign consuming = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign restart   = start && (state inside {IDLE, DONE, ERR});
  assign lane3_pop = q_remove && (state == DATA) && (idx == 2'd3);
  assign last_word = (rx_words == len - 16'd1);

  // Pop only when the queue will honour it: a remove colliding with an add is dropped.
  assign q_remove = consuming && !q_empty && !wr_active;
  assign busy     = consuming;
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
      LEN_LO:          if (q_remove) state_nxt = LEN_HI;
      LEN_HI: if (q_remove) begin
        if ({1'b0, len_full} > MAX_LEN) state_nxt = ERR;
        else if (len_full == 16'd0)      state_nxt = CSUM;
        else                             state_nxt = DATA;
      end
      DATA:   if (lane3_pop && last_word) state_nxt = CSUM;
      CSUM:   if (q_remove) state_nxt = (q_data == csum) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len           <= '0;
      rx_words      <= '0;
      idx           <= '0;
      lane          <= '0;
      csum          <= '0;
      addr          <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
    end else begin
      mem_we <= lane3_pop;
      // The write launched last cycle retires here; address and count step together.
      if (mem_we) begin
        addr          <= addr + 1'b1;
        words_written <= words_written + 16'd1;
      end
      if (restart) begin
        words_written <= '0;
        csum          <= '0;
        addr          <= BASE;
        rx_words      <= '0;
        idx           <= '0;
      end
      if (q_remove) begin
        case (state)
          LEN_LO: len[7:0] <= q_data;
          LEN_HI: begin
            len[15:8] <= q_data;
            idx       <= '0;
          end
          DATA: begin
            csum <= csum ^ q_data;
            idx  <= idx + 2'd1;
            for (int i = 0; i < 3; i++)
              if (idx == 2'(i)) lane[i] <= q_data;
            if (idx == 2'd3) begin
              mem_wdata <= {q_data, lane[2], lane[1], lane[0]};
              mem_addr  <= addr;
              rx_words  <= rx_words + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench for boot_image_loader: a byte-queue model feeds framed images,
// and a negedge monitor logs memory writes, pops and illegal pop attempts.
module tb_boot_image_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_active = 1'b0;
  logic        q_empty, q_remove, mem_we, busy, done, err;
  logic [7:0]  q_data;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_written;

  int checks = 0, failures = 0;

  boot_image_loader #(.ADDR_W(14), .BASE_ADDR(16), .MAX_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_empty(q_empty), .q_data(q_data),
    .wr_active(wr_active), .q_remove(q_remove), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Queue model
  logic [7:0] bq [0:255];
  int   wptr = 0, rptr = 0;
  logic flush = 1'b0, stall = 1'b0;
  assign q_empty = stall || (rptr == wptr);
  assign q_data  = bq[rptr[7:0]];
  always @(posedge clk) begin
    if (flush)         rptr <= wptr;
    else if (q_remove) rptr <= rptr + 1;
  end

  // Monitor
  int          nw = 0, npop = 0, viol = 0;
  logic [13:0] wa [0:63];
  logic [31:0] wd [0:63];
  always @(negedge clk) begin
    if (mem_we) begin
      wa[nw] = mem_addr;
      wd[nw] = mem_wdata;
      nw++;
    end
    if (q_remove) npop++;
    if (q_remove && (q_empty || wr_active)) viol++;
  end

  task automatic push(input logic [7:0] b);
    bq[wptr[7:0]] = b;
    wptr++;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0;
  endtask

  task automatic pulse_start();
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done || err) break;
      cyc();
    end
    checks++;
    if (!(done || err)) begin
      failures++;
      $display("FAIL timeout got done=%0b err=%0b required done|err=1", done, err);
    end
  endtask

  task automatic push_basic();
    push(8'h02); push(8'h00);
    push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
    push(8'h2A);
  endtask

  task automatic check_basic(input int nb, input string tag);
    checks++;
    if (nw - nb !== 2) begin failures++; $display("FAIL %s_nwrites got=%0d exp=2", tag, nw - nb); end
    checks++;
    if (wa[nb] !== 14'd16 || wd[nb] !== 32'h12345678) begin
      failures++; $display("FAIL %s_w0 got=%0h@%0d exp=12345678@16", tag, wd[nb], wa[nb]);
    end
    checks++;
    if (wa[nb+1] !== 14'd17 || wd[nb+1] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL %s_w1 got=%0h@%0d exp=deadbeef@17", tag, wd[nb+1], wa[nb+1]);
    end
    checks++;
    if ({done, err, busy} !== 3'b100 || words_written !== 16'd2) begin
      failures++;
      $display("FAIL %s_status got done=%0b err=%0b busy=%0b ww=%0d exp 1 0 0 2", tag, done, err, busy, words_written);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({q_remove, mem_we, mem_addr, mem_wdata, busy, done, err, words_written} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%0b addr=%0h wdata=%0h busy=%0b done=%0b err=%0b ww=%0d exp all 0",
               mem_we, mem_addr, mem_wdata, busy, done, err, words_written);
    end
    cyc(); cyc(); rst_n = 1'b1;
    cyc(); cyc();
    checks++;
    if ({busy, done, err, q_remove} !== 4'b0) begin
      failures++; $display("FAIL reset_idle got busy=%0b done=%0b err=%0b exp 0 0 0", busy, done, err);
    end
  endtask

  task automatic test_basic();
    int nb;
    do_flush();
    push_basic();
    nb = nw;
    pulse_start();
    wait_end(100);
    check_basic(nb, "basic");
    cyc();
    checks++;
    if (mem_addr !== 14'd17 || mem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL basic_hold got=%0h@%0d exp=deadbeef@17", mem_wdata, mem_addr);
    end
  endtask

  task automatic test_zero_len();
    int nb, pb;
    do_flush();
    push(8'h00); push(8'h00); push(8'h00);
    nb = nw; pb = npop;
    pulse_start();
    wait_end(50);
    checks++;
    if (nw - nb !== 0 || npop - pb !== 3) begin
      failures++; $display("FAIL zero_len got writes=%0d pops=%0d exp 0 3", nw - nb, npop - pb);
    end
    checks++;
    if ({done, err} !== 2'b10 || words_written !== 16'd0) begin
      failures++; $display("FAIL zero_len_status got done=%0b err=%0b ww=%0d exp 1 0 0", done, err, words_written);
    end
  endtask

  task automatic test_bad_csum();
    int nb;
    do_flush();
    push(8'h01); push(8'h00);
    push(8'h04); push(8'h03); push(8'h02); push(8'h01);
    push(8'h05);
    nb = nw;
    pulse_start();
    wait_end(50);
    checks++;
    if (nw - nb !== 1 || wd[nb] !== 32'h01020304 || wa[nb] !== 14'd16) begin
      failures++; $display("FAIL bad_csum_write got n=%0d %0h@%0d exp 1 01020304@16", nw - nb, wd[nb], wa[nb]);
    end
    checks++;
    if ({done, err, busy} !== 3'b010 || words_written !== 16'd1) begin
      failures++;
      $display("FAIL bad_csum_status got done=%0b err=%0b busy=%0b ww=%0d exp 0 1 0 1", done, err, busy, words_written);
    end
  endtask

  task automatic test_oversize();
    int nb, pb;
    do_flush();
    push(8'h09); push(8'h00); push(8'hAA);
    nb = nw; pb = npop;
    pulse_start();
    wait_end(50);
    cyc(); cyc(); cyc();
    checks++;
    if (npop - pb !== 2 || nw - nb !== 0) begin
      failures++; $display("FAIL oversize_pops got pops=%0d writes=%0d exp 2 0", npop - pb, nw - nb);
    end
    checks++;
    if ({done, err, busy} !== 3'b010 || q_data !== 8'hAA) begin
      failures++; $display("FAIL oversize_status got done=%0b err=%0b busy=%0b head=%0h exp 0 1 0 aa", done, err, busy, q_data);
    end
  endtask

  task automatic test_contention();
    int nb, vb, c;
    do_flush();
    push(8'h03); push(8'h00);
    for (int i = 1; i <= 12; i++) push(8'(i));
    push(8'h0C);
    nb = nw; vb = viol;
    pulse_start();
    c = 0;
    while (!(done || err) && c < 300) begin
      wr_active = c[0];
      stall     = (c % 3 == 0);
      cyc();
      c++;
    end
    wr_active = 1'b0; stall = 1'b0;
    wait_end(20);
    checks++;
    if (viol - vb !== 0) begin failures++; $display("FAIL contention_pop_rule got=%0d illegal pops exp=0", viol - vb); end
    checks++;
    if (nw - nb !== 3 || wd[nb] !== 32'h04030201 || wd[nb+1] !== 32'h08070605 || wd[nb+2] !== 32'h0C0B0A09) begin
      failures++; $display("FAIL contention_data got n=%0d %0h %0h %0h exp 3 04030201 08070605 0c0b0a09",
                           nw - nb, wd[nb], wd[nb+1], wd[nb+2]);
    end
    checks++;
    if (wa[nb] !== 14'd16 || wa[nb+1] !== 14'd17 || wa[nb+2] !== 14'd18) begin
      failures++; $display("FAIL contention_addr got %0d %0d %0d exp 16 17 18", wa[nb], wa[nb+1], wa[nb+2]);
    end
    checks++;
    if ({done, err} !== 2'b10 || words_written !== 16'd3) begin
      failures++; $display("FAIL contention_status got done=%0b err=%0b ww=%0d exp 1 0 3", done, err, words_written);
    end
  endtask

  task automatic test_reset_mid();
    int nb, pb, k;
    do_flush();
    push(8'h02); push(8'h00); push(8'hAA); push(8'hBB);
    nb = nw; pb = npop;
    pulse_start();
    k = 0;
    while (npop - pb < 4 && k < 50) begin cyc(); k++; end
    cyc(); cyc();
    checks++;
    if (busy !== 1'b1 || npop - pb !== 4) begin
      failures++; $display("FAIL reset_mid_pre got busy=%0b pops=%0d exp 1 4", busy, npop - pb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q_remove, mem_we, mem_addr, mem_wdata, busy, done, err, words_written} !== '0 || nw - nb !== 0) begin
      failures++;
      $display("FAIL reset_mid_outputs got we=%0b addr=%0h wdata=%0h busy=%0b ww=%0d writes=%0d exp all 0",
               mem_we, mem_addr, mem_wdata, busy, words_written, nw - nb);
    end
    cyc(); cyc(); rst_n = 1'b1;
    do_flush();
    push_basic();
    nb = nw;
    pulse_start();
    wait_end(100);
    check_basic(nb, "reset_reload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_bad_csum();
    test_oversize();
    test_contention();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/boot_image_loader.md
Name: boot_image_loader

Overview:
- Drains the bootloader's 8-deep byte queue on the consumer side, the counterpart of the serial receiver that fills it.
- Parses a framed boot image from the byte stream: 2-byte word count, 4 data bytes per word, 1 checksum byte.
- Assembles little-endian 32-bit words and writes them to instruction memory at consecutive word addresses starting at BASE_ADDR.
- Reports done, or error on a checksum or length fault.

Parameters:
- ADDR_W, 14, instruction-memory word-address width.
- BASE_ADDR, 0, word address of the first data word.
- MAX_WORDS, 4096, largest legal word count; must satisfy BASE_ADDR+MAX_WORDS <= 2**ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  single-cycle pulse that begins a load
- q_empty  in  1  queue empty flag
- q_data  in  8  queue head byte; combinational, valid while !q_empty
- wr_active  in  1  producer's add strobe this cycle; the queue drops a remove when add is high in the same cycle
- q_remove  out  1  pop strobe
- mem_we  out  1  instruction-memory write enable, one cycle per word
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- busy  out  1  load in progress
- done  out  1  sticky; image loaded and checksum good
- err  out  1  sticky; checksum mismatch or length > MAX_WORDS
- words_written  out  16  count of mem_we pulses in the current load

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - State goes to IDLE.
  - All outputs go to 0, including mem_addr, mem_wdata and words_written.
  - Internal byte index, checksum, length and address counters go to 0.
  - Reset mid-load aborts with no further memory writes. Bytes left in the queue are not flushed.
- Pop rule (combinational, Moore-safe):
  - q_remove = in a consuming state && !q_empty && !wr_active.
  - A byte is taken exactly in a cycle where q_remove=1; the state machine advances only on such cycles.
  - Back-to-back pops every cycle are legal. The head byte updates the cycle after a pop.
  - Never assert q_remove when q_empty=1 or wr_active=1.
- States:
  - IDLE: start -> LEN_LO. Clear done, err, words_written and checksum. Load address = BASE_ADDR.
  - LEN_LO: pop -> len[7:0]; go to LEN_HI.
  - LEN_HI: pop -> len[15:8], then:
    - len > MAX_WORDS -> ERR;
    - len == 0 -> CSUM;
    - otherwise DATA with byte index = 0.
  - DATA:
    - Each pop stores q_data into word byte lane [index]; byte 0 goes to bits 7:0.
    - Each pop updates checksum ^= q_data.
    - Index wraps 3 -> 0.
    - On the pop of lane 3, the next cycle drives:
      - mem_we=1 for exactly one cycle;
      - mem_wdata = assembled word;
      - mem_addr = current address.
    - Then the address increments and words_written increments, both in the cycle after mem_we.
    - When the last word's lane 3 is popped -> CSUM; the final write still occurs in the following cycle.
  - CSUM: pop; q_data == checksum -> DONE, otherwise -> ERR. The checksum covers data bytes only, not length bytes.
  - DONE: done=1, busy=0. start -> LEN_LO, same clearing as IDLE.
  - ERR: err=1, busy=0. start -> LEN_LO, same clearing as IDLE.
- busy = 1 in LEN_LO, LEN_HI, DATA and CSUM.
- start is ignored while busy.
- Idle-state outputs:
  - mem_addr and mem_wdata hold their last values when mem_we=0.
  - words_written holds its value in DONE and ERR.
- Stalls: an empty queue or wr_active stalls indefinitely; there is no timeout. Partial word state is preserved across a stall.
- Width: 16-bit length, ADDR_W-bit address. The address cannot overflow when the MAX_WORDS constraint holds.

Test Plan:
- Basic load, queue pre-filled, no stalls:
  - Image 02 00 | 78 56 34 12 | EF BE AD DE | csum.
  - Required: writes 0x12345678 @BASE_ADDR and 0xDEADBEEF @BASE_ADDR+1, one mem_we each.
  - Required: done=1, words_written=2, err=0.
- Zero length: bytes 00 00 00 -> no mem_we, done=1 after 3 pops.
- Bad checksum: N=1 image with checksum byte off by 0x01 -> word still written, err=1, done=0, busy=0.
- Oversize length: N = MAX_WORDS+1 -> ERR after the 2nd pop, no mem_we, the 3rd byte is not popped.
- Producer contention: hold wr_active=1 on every other cycle and toggle q_empty during an N=3 load.
  - Required: q_remove never high with wr_active or q_empty.
  - Required: three correct words and done=1.
- Reset mid-DATA: assert rst_n=0 after 2 bytes of word 0 -> all outputs 0, IDLE, no mem_we.
  - Then pulse start with a fresh image -> loads correctly from BASE_ADDR.
